// File: rtl/key_extract_pkg.sv
// Shared constants, comparator op encodings and helpers for the key extractor.
package key_extract_pkg;

    localparam int unsigned HDR_LEN      = 1024;
    localparam int unsigned COND_W       = 21;
    localparam logic [7:0]  OFF_DISABLED = 8'hFF;

    localparam int unsigned DEF_COND_OFF = 256;
    localparam int unsigned DEF_CONT_OFF = 356;
    localparam int unsigned DEF_HDR_OFF  = 556;

    typedef enum logic [2:0] {
        OP_GT       = 3'b000,
        OP_GE       = 3'b001,
        OP_EQ       = 3'b010,
        OP_NE       = 3'b011,
        OP_LT       = 3'b100,
        OP_LE       = 3'b101,
        OP_TRUE     = 3'b110,
        OP_TRUE_ALT = 3'b111
    } cond_op_e;

    // Header byte idx counted from the header MSB; indices >= 128 read as 0.
    function automatic logic [7:0] hdr_byte(input logic [HDR_LEN-1:0] hdr,
                                            input logic [7:0]         idx);
        logic [HDR_LEN-1:0] sh;
        sh = hdr >> (10'd1016 - {idx[6:0], 3'b000});
        return idx[7] ? 8'h00 : sh[7:0];
    endfunction

    // Unsigned 8-bit comparison selected by op.
    function automatic logic cond_eval(input cond_op_e   op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        case (op)
            OP_GT:   return a >  b;
            OP_GE:   return a >= b;
            OP_EQ:   return a == b;
            OP_NE:   return a != b;
            OP_LT:   return a <  b;
            OP_LE:   return a <= b;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/key_extract_pipe_field_sel.sv
// key_field_sel: picks a W-bit field at a byte offset from the header MSB and
// flags whether the offset is enabled and the field fits inside the header.
module key_field_sel
    import key_extract_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [HDR_LEN-1:0] hdr,
    input  logic [7:0]         off,
    output logic [W-1:0]       field,
    output logic               in_range
);

    logic [11:0]        end_bit;
    logic [HDR_LEN-1:0] shifted;

    // Field occupies header bits counted down from the MSB; shift it to bit 0.
    always_comb begin
        end_bit  = {1'b0, off, 3'b000} + 12'(W);
        in_range = (off != OFF_DISABLED) && (end_bit <= 12'(HDR_LEN));
        shifted  = hdr >> (12'(HDR_LEN) - end_bit);
        field    = in_range ? shifted[W-1:0] : '0;
    end

endmodule

// File: rtl/key_extract_pipe.sv
// key_extract_pipe: two-stage pipelined lookup-key, mask and condition builder
// with valid/ready backpressure. Optional comparator: KEY_EXTRACT_COND_EN.
module key_extract_pipe
    import key_extract_pkg::*;
#(
    parameter int unsigned NUM_2B   = 8,
    parameter int unsigned NUM_4B   = 8,
    parameter int unsigned NUM_8B   = 8,
    parameter int unsigned KEY_LEN  = 16*NUM_2B + 32*NUM_4B + 64*NUM_8B,
    parameter int unsigned COND_OFF = DEF_COND_OFF,
    parameter int unsigned CONT_OFF = DEF_CONT_OFF,
    parameter int unsigned HDR_OFF  = DEF_HDR_OFF,
    parameter int unsigned PHV_LEN  = 1580
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHV_LEN-1:0] pkt_hdr_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [KEY_LEN-1:0] extract_key,
    output logic [KEY_LEN-1:0] key_mask,
    output logic               cond_flag,
    output logic [PHV_LEN-1:0] pkt_hdr_vec_out
);

    localparam int unsigned NUM_CONT = NUM_2B + NUM_4B + NUM_8B;
    localparam int unsigned KEY_USED = 16*NUM_2B + 32*NUM_4B + 64*NUM_8B;

    logic                en;
    logic [HDR_LEN-1:0]  hdr;
    logic [KEY_LEN-1:0]  sel_key;
    logic [NUM_CONT-1:0] sel_rng;
    logic [KEY_LEN-1:0]  mask_exp;

    logic                s1_valid_q, s1_valid_d;
    logic [KEY_LEN-1:0]  s1_key_q,   s1_key_d;
    logic [NUM_CONT-1:0] s1_rng_q,   s1_rng_d;
    logic [PHV_LEN-1:0]  s1_phv_q,   s1_phv_d;
    logic                s2_valid_q, s2_valid_d;
    logic [KEY_LEN-1:0]  s2_key_q,   s2_key_d;
    logic [KEY_LEN-1:0]  s2_mask_q,  s2_mask_d;
    logic                s2_cond_q,  s2_cond_d;
    logic [PHV_LEN-1:0]  s2_phv_q,   s2_phv_d;

    assign en       = ~s2_valid_q | out_ready;
    assign in_ready = en;
    assign hdr      = pkt_hdr_vec[HDR_OFF +: HDR_LEN];

    // Field selectors write straight into their final key positions.
    for (genvar i = 0; i < NUM_2B; i++) begin : g_2b
        key_field_sel #(.W(16)) u_sel (
            .hdr      (hdr),
            .off      (pkt_hdr_vec[CONT_OFF + 8*(NUM_8B + NUM_4B + i) +: 8]),
            .field    (sel_key[KEY_LEN - 16*(i+1) +: 16]),
            .in_range (sel_rng[i])
        );
    end
    for (genvar i = 0; i < NUM_4B; i++) begin : g_4b
        key_field_sel #(.W(32)) u_sel (
            .hdr      (hdr),
            .off      (pkt_hdr_vec[CONT_OFF + 8*(NUM_8B + i) +: 8]),
            .field    (sel_key[KEY_LEN - 16*NUM_2B - 32*(i+1) +: 32]),
            .in_range (sel_rng[NUM_2B + i])
        );
    end
    for (genvar i = 0; i < NUM_8B; i++) begin : g_8b
        key_field_sel #(.W(64)) u_sel (
            .hdr      (hdr),
            .off      (pkt_hdr_vec[CONT_OFF + 8*i +: 8]),
            .field    (sel_key[KEY_LEN - 16*NUM_2B - 32*NUM_4B - 64*(i+1) +: 64]),
            .in_range (sel_rng[NUM_2B + NUM_4B + i])
        );
    end
    if (KEY_LEN > KEY_USED) begin : g_key_pad
        assign sel_key[KEY_LEN-KEY_USED-1:0] = '0;
    end

    // Stage 1 capture: fields, range bits and PHV load only on an accepted input.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_key_d   = s1_key_q;
        s1_rng_d   = s1_rng_q;
        s1_phv_d   = s1_phv_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_key_d = sel_key;
                s1_rng_d = sel_rng;
                s1_phv_d = pkt_hdr_vec;
            end
        end
    end

    // Expand per-container range bits into per-bit mask at the key positions.
    always_comb begin
        mask_exp = '0;
        for (int unsigned i = 0; i < NUM_2B; i++)
            mask_exp[KEY_LEN - 16*(i+1) +: 16] = {16{s1_rng_q[i]}};
        for (int unsigned i = 0; i < NUM_4B; i++)
            mask_exp[KEY_LEN - 16*NUM_2B - 32*(i+1) +: 32] = {32{s1_rng_q[NUM_2B + i]}};
        for (int unsigned i = 0; i < NUM_8B; i++)
            mask_exp[KEY_LEN - 16*NUM_2B - 32*NUM_4B - 64*(i+1) +: 64] =
                {64{s1_rng_q[NUM_2B + NUM_4B + i]}};
    end

`ifdef KEY_EXTRACT_COND_EN
    logic [COND_W-1:0] cond_word;
    cond_op_e          s1_op_q, s1_op_d;
    logic [7:0]        s1_a_q,  s1_a_d;
    logic [7:0]        s1_b_q,  s1_b_d;

    // Stage 1 operand fetch: literal or header byte per imm bit.
    always_comb begin
        cond_word = pkt_hdr_vec[COND_OFF +: COND_W];
        s1_op_d   = s1_op_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        if (en && in_valid) begin
            s1_op_d = cond_op_e'(cond_word[20:18]);
            s1_a_d  = cond_word[17] ? cond_word[16:9] : hdr_byte(hdr, cond_word[16:9]);
            s1_b_d  = cond_word[8]  ? cond_word[7:0]  : hdr_byte(hdr, cond_word[7:0]);
        end
    end

    // Stage 1 operand registers.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            s1_op_q <= OP_GT;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
        end else begin
            s1_op_q <= s1_op_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
        end
    end
`endif

    // Stage 2 capture: key, mask, condition and PHV advance together.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_key_d   = s2_key_q;
        s2_mask_d  = s2_mask_q;
        s2_cond_d  = s2_cond_q;
        s2_phv_d   = s2_phv_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_key_d  = s1_key_q;
                s2_mask_d = mask_exp;
                s2_phv_d  = s1_phv_q;
`ifdef KEY_EXTRACT_COND_EN
                s2_cond_d = cond_eval(s1_op_q, s1_a_q, s1_b_q);
`else
                s2_cond_d = 1'b1;
`endif
            end
        end
    end

    // Pipeline registers; synchronous reset flushes both stages.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_key_q   <= '0;
            s1_rng_q   <= '0;
            s1_phv_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_key_q   <= '0;
            s2_mask_q  <= '0;
            s2_cond_q  <= 1'b1;
            s2_phv_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_key_q   <= s1_key_d;
            s1_rng_q   <= s1_rng_d;
            s1_phv_q   <= s1_phv_d;
            s2_valid_q <= s2_valid_d;
            s2_key_q   <= s2_key_d;
            s2_mask_q  <= s2_mask_d;
            s2_cond_q  <= s2_cond_d;
            s2_phv_q   <= s2_phv_d;
        end
    end

    assign out_valid       = s2_valid_q;
    assign extract_key     = s2_key_q;
    assign key_mask        = s2_mask_q;
    assign cond_flag       = s2_cond_q;
    assign pkt_hdr_vec_out = s2_phv_q;

endmodule

// File: tb/tb_key_extract_pipe.sv
// Directed self-checking bench for key_extract_pipe (default parameters).
// Comparator expectations follow KEY_EXTRACT_COND_EN when it is defined.
module tb_key_extract_pipe;

    localparam int unsigned KL = 896;
    localparam int unsigned PL = 1580;
    localparam int unsigned CO = 256;
    localparam int unsigned TO = 356;
    localparam int unsigned HO = 556;

    typedef struct packed {
        logic [2:0] op;
        logic       i1;
        logic [7:0] o1;
        logic       i2;
        logic [7:0] o2;
        logic       exp;
    } cvec_t;

    localparam cvec_t CV [11] = '{
        '{3'b100, 1'b1, 8'd5,   1'b0, 8'd10,  1'b1},
        '{3'b000, 1'b1, 8'd5,   1'b0, 8'd10,  1'b0},
        '{3'b011, 1'b1, 8'd5,   1'b0, 8'd10,  1'b1},
        '{3'b110, 1'b1, 8'd5,   1'b0, 8'd10,  1'b1},
        '{3'b010, 1'b1, 8'd5,   1'b0, 8'd10,  1'b0},
        '{3'b101, 1'b1, 8'd5,   1'b0, 8'd10,  1'b1},
        '{3'b001, 1'b1, 8'd5,   1'b0, 8'd10,  1'b0},
        '{3'b111, 1'b1, 8'd5,   1'b0, 8'd10,  1'b1},
        '{3'b010, 1'b1, 8'd0,   1'b0, 8'd200, 1'b1},
        '{3'b000, 1'b0, 8'd127, 1'b1, 8'd126, 1'b1},
        '{3'b100, 1'b0, 8'd3,   1'b1, 8'd3,   1'b0}
    };

    logic          axis_clk = 1'b0;
    logic          aresetn;
    logic          in_valid;
    logic          in_ready;
    logic [PL-1:0] pkt_hdr_vec;
    logic          out_valid;
    logic          out_ready;
    logic [KL-1:0] extract_key;
    logic [KL-1:0] key_mask;
    logic          cond_flag;
    logic [PL-1:0] pkt_hdr_vec_out;

    logic [PL-1:0] phv_v;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 axis_clk = ~axis_clk;

    key_extract_pipe #(
        .NUM_2B   (8),
        .NUM_4B   (8),
        .NUM_8B   (8),
        .KEY_LEN  (KL),
        .COND_OFF (CO),
        .CONT_OFF (TO),
        .HDR_OFF  (HO),
        .PHV_LEN  (PL)
    ) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pkt_hdr_vec     (pkt_hdr_vec),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .extract_key     (extract_key),
        .key_mask        (key_mask),
        .cond_flag       (cond_flag),
        .pkt_hdr_vec_out (pkt_hdr_vec_out)
    );

    // Header byte i = i, all containers disabled, tag in spare bits.
    task automatic init_phv(input logic [7:0] tag);
        phv_v = '0;
        for (int i = 0; i < 128; i++) phv_v[HO + 1023 - 8*i -: 8] = 8'(i);
        for (int j = 0; j < 24; j++)  phv_v[TO + 8*j +: 8] = 8'hFF;
        phv_v[7:0]     = tag;
        phv_v[555:548] = tag;
    endtask

    task automatic set_off(input int kind, input int idx, input logic [7:0] v);
        int pos;
        pos = (kind == 8) ? idx : (kind == 4) ? 8 + idx : 16 + idx;
        phv_v[TO + 8*pos +: 8] = v;
    endtask

    task automatic set_cond(input cvec_t c);
        phv_v[CO +: 21] = {c.op, c.i1, c.o1, c.i2, c.o2};
    endtask

    // Sends phv_v once and waits (bounded) for out_valid; lat counts edges.
    task automatic run_one(output logic got, output int lat);
        got = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        pkt_hdr_vec = phv_v;
        @(posedge axis_clk); #1;
        in_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge axis_clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        pkt_hdr_vec = '1;
        repeat (3) @(posedge axis_clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_checks++; if (extract_key !== '0) begin n_fail++; $display("FAIL rst_key got %h exp 0", extract_key); end
        n_checks++; if (key_mask !== '0) begin n_fail++; $display("FAIL rst_mask got %h exp 0", key_mask); end
        n_checks++; if (cond_flag !== 1'b1) begin n_fail++; $display("FAIL rst_cond got %b exp 1", cond_flag); end
        n_checks++; if (pkt_hdr_vec_out !== '0) begin n_fail++; $display("FAIL rst_phv got tag %h exp 0", pkt_hdr_vec_out[7:0]); end
        in_valid = 1'b0;
        aresetn = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        @(posedge axis_clk); #1;
    endtask

    task automatic test_field_extract();
        logic [KL-1:0] ek, em;
        logic got;
        int lat;
        init_phv(8'h11);
        set_off(2, 0, 8'd4);
        set_off(4, 0, 8'd0);
        set_off(8, 7, 8'd120);
        ek = {16'h0405, 112'h0, 32'h00010203, 224'h0, 448'h0, 64'h78797A7B7C7D7E7F};
        em = {16'hFFFF, 112'h0, 32'hFFFFFFFF, 224'h0, 448'h0, 64'hFFFFFFFFFFFFFFFF};
        run_one(got, lat);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL fx_timeout got %b exp 1", got); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL fx_latency got %0d exp 2", lat); end
        n_checks++; if (extract_key !== ek) begin n_fail++; $display("FAIL fx_key got %h exp %h", extract_key, ek); end
        n_checks++; if (key_mask !== em) begin n_fail++; $display("FAIL fx_mask got %h exp %h", key_mask, em); end
        n_checks++; if (pkt_hdr_vec_out !== phv_v) begin n_fail++; $display("FAIL fx_phv got tag %h exp tag %h", pkt_hdr_vec_out[7:0], phv_v[7:0]); end
        @(posedge axis_clk); #1;
    endtask

    task automatic test_disabled_range();
        logic [KL-1:0] ek, em;
        logic got;
        int lat;
        init_phv(8'h22);
        set_off(2, 0, 8'd4);
        set_off(2, 1, 8'hFF);
        set_off(2, 2, 8'd126);
        set_off(4, 0, 8'd0);
        set_off(4, 1, 8'd124);
        set_off(4, 2, 8'd125);
        set_off(8, 0, 8'd125);
        set_off(8, 7, 8'd120);
        ek = {16'h0405, 16'h0, 16'h7E7F, 80'h0,
              32'h00010203, 32'h7C7D7E7F, 192'h0,
              448'h0, 64'h78797A7B7C7D7E7F};
        em = {16'hFFFF, 16'h0, 16'hFFFF, 80'h0,
              32'hFFFFFFFF, 32'hFFFFFFFF, 192'h0,
              448'h0, 64'hFFFFFFFFFFFFFFFF};
        run_one(got, lat);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL dr_timeout got %b exp 1", got); end
        n_checks++; if (extract_key !== ek) begin n_fail++; $display("FAIL dr_key got %h exp %h", extract_key, ek); end
        n_checks++; if (key_mask !== em) begin n_fail++; $display("FAIL dr_mask got %h exp %h", key_mask, em); end
        @(posedge axis_clk); #1;
    endtask

    task automatic test_cond();
        logic got;
        int lat;
        logic exp_c;
        for (int i = 0; i < 11; i++) begin
            init_phv(8'(8'h30 + i));
            set_cond(CV[i]);
`ifdef KEY_EXTRACT_COND_EN
            exp_c = CV[i].exp;
`else
            exp_c = 1'b1;
`endif
            run_one(got, lat);
            n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL cond_timeout[%0d] got %b exp 1", i, got); end
            n_checks++; if (cond_flag !== exp_c) begin n_fail++; $display("FAIL cond[%0d] op %b got %b exp %b", i, CV[i].op, cond_flag, exp_c); end
        end
        @(posedge axis_clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [PL-1:0] bp_vec [4];
        logic [KL-1:0] bp_key [4];
        int sent, rcv;
        logic acc;
        for (int i = 0; i < 4; i++) begin
            init_phv(8'(8'hA0 + i));
            set_off(2, 0, 8'(2*i));
            bp_vec[i] = phv_v;
            bp_key[i] = '0;
            bp_key[i][KL-1 -: 16] = {8'(2*i), 8'(2*i + 1)};
        end
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c >= 5);
            in_valid = (sent < 4);
            pkt_hdr_vec = bp_vec[(sent < 4) ? sent : 3];
            #1;
            if (c == 2) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drop got %b exp 0", in_ready); end
                n_checks++; if (sent != 2) begin n_fail++; $display("FAIL bp_accepted got %0d exp 2", sent); end
            end
            if (c == 4) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid got %b exp 1", out_valid); end
                n_checks++; if (pkt_hdr_vec_out !== bp_vec[0]) begin n_fail++; $display("FAIL bp_stall_hold got tag %h exp tag %h", pkt_hdr_vec_out[7:0], bp_vec[0][7:0]); end
            end
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                if (rcv < 4) begin
                    n_checks++; if (pkt_hdr_vec_out !== bp_vec[rcv]) begin n_fail++; $display("FAIL bp_order_phv[%0d] got tag %h exp tag %h", rcv, pkt_hdr_vec_out[7:0], bp_vec[rcv][7:0]); end
                    n_checks++; if (extract_key !== bp_key[rcv]) begin n_fail++; $display("FAIL bp_key[%0d] got %h exp %h", rcv, extract_key[KL-1 -: 16], bp_key[rcv][KL-1 -: 16]); end
                end
                rcv++;
            end
            @(posedge axis_clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        n_checks++; if (rcv != 4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", rcv); end
    endtask

    task automatic test_reset_midflight();
        logic got;
        int lat;
        logic [KL-1:0] ek;
        out_ready = 1'b1;
        init_phv(8'hC0);
        set_off(2, 0, 8'd6);
        in_valid = 1'b1;
        pkt_hdr_vec = phv_v;
        @(posedge axis_clk); #1;
        init_phv(8'hC1);
        pkt_hdr_vec = phv_v;
        @(posedge axis_clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pre_valid got %b exp 1", out_valid); end
        in_valid = 1'b0;
        aresetn = 1'b0;
        @(posedge axis_clk); #1;
        aresetn = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid got %b exp 0", out_valid); end
        n_checks++; if (extract_key !== '0) begin n_fail++; $display("FAIL mr_key got %h exp 0", extract_key); end
        n_checks++; if (key_mask !== '0) begin n_fail++; $display("FAIL mr_mask got %h exp 0", key_mask); end
        n_checks++; if (cond_flag !== 1'b1) begin n_fail++; $display("FAIL mr_cond got %b exp 1", cond_flag); end
        n_checks++; if (pkt_hdr_vec_out !== '0) begin n_fail++; $display("FAIL mr_phv got tag %h exp 0", pkt_hdr_vec_out[7:0]); end
        for (int k = 0; k < 3; k++) begin
            @(posedge axis_clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_idle_valid[%0d] got %b exp 0", k, out_valid); end
        end
        init_phv(8'hC2);
        set_off(2, 0, 8'd8);
        ek = '0;
        ek[KL-1 -: 16] = 16'h0809;
        run_one(got, lat);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mr_new_timeout got %b exp 1", got); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mr_new_latency got %0d exp 2", lat); end
        n_checks++; if (extract_key !== ek) begin n_fail++; $display("FAIL mr_new_key got %h exp %h", extract_key[KL-1 -: 16], ek[KL-1 -: 16]); end
        n_checks++; if (pkt_hdr_vec_out !== phv_v) begin n_fail++; $display("FAIL mr_new_phv got tag %h exp tag %h", pkt_hdr_vec_out[7:0], phv_v[7:0]); end
        @(posedge axis_clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pkt_hdr_vec = '0;
        test_reset();
        test_field_extract();
        test_disabled_range();
        test_cond();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
